// File: rtl/uart_pkg.sv
// Shared types for the UART frame controller: parser states, error codes
// and the default frame start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_TIMEOUT
  } err_code_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register array with one synchronous write port and a
// combinational read port; the parent registers the read data.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; a frame is only read back after
  // every slot it uses has been written, so reset would only add wiring.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Framed-packet parser behind a UART receiver: SYNC, LEN, payload, XOR
// checksum; releases only verified payloads on a valid/ready stream.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter real        CLK_Hz       = 66_000_000.0,
  parameter real        BITRATE_bps  = 9_600.0,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] overrun_cnt,
  output logic       busy
);

  localparam int         TIMEOUT_CLK = int'(CLK_Hz / BITRATE_bps * TIMEOUT_BITS);
  localparam int         LW          = $clog2(MAX_LEN + 1);
  localparam int         IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW          = $clog2(TIMEOUT_CLK + 1);
  localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);

  state_e        state_q, state_d;
  err_code_e     err_q, err_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          ok_q, ok_d;
  logic          errp_q, errp_d;
  logic          pv_q, pv_d;
  logic          pl_q, pl_d;
  logic [7:0]    pd_q, pd_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          drain_adv;
  logic [LW-1:0] rd_nxt;
  logic          tmo_expire;

  // Address the buffer with the next read index so the registered output
  // already holds the following byte once a handshake completes.
  assign drain_adv  = (state_q == DRAIN) && pv_q && pkt_ready && !pl_q;
  assign rd_nxt     = rd_q + LW'(drain_adv);
  assign tmo_expire = (tmo_q == TW'(TIMEOUT_CLK - 1));

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[IW-1:0]),
    .wdata (rx_data),
    .raddr (rd_nxt[IW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    ovr_d   = ovr_q;
    ok_d    = 1'b0;
    errp_d  = 1'b0;
    pv_d    = pv_q;
    pl_d    = pl_q;
    pd_d    = pd_q;
    buf_we  = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data != 8'h00 && rx_data <= MAX_LEN_B) begin
            len_d   = rx_data[LW-1:0];
            csum_d  = rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end else begin
            errp_d  = 1'b1;
            err_d   = ERR_LEN;
            state_d = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 1'b1;
          if (idx_d == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            ok_d    = 1'b1;
            err_d   = ERR_NONE;
            rd_d    = '0;
            state_d = DRAIN;
          end else begin
            errp_d  = 1'b1;
            err_d   = ERR_CSUM;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        if (rx_valid && ovr_q != 8'hFF) ovr_d = ovr_q + 1'b1;
        if (!pv_q) begin
          pv_d = 1'b1;
          pd_d = buf_rdata;
          pl_d = (rd_q == len_q - 1'b1);
        end else if (pkt_ready) begin
          if (pl_q) begin
            pv_d    = 1'b0;
            pl_d    = 1'b0;
            state_d = HUNT;
          end else begin
            rd_d = rd_nxt;
            pd_d = buf_rdata;
            pl_d = (rd_nxt == len_q - 1'b1);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if ((state_q == LEN || state_q == PAYLOAD || state_q == CSUM) && !rx_valid) begin
      if (tmo_expire) begin
        errp_d  = 1'b1;
        err_d   = ERR_TIMEOUT;
        state_d = HUNT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      err_q   <= ERR_NONE;
      len_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      ovr_q   <= '0;
      ok_q    <= 1'b0;
      errp_q  <= 1'b0;
      pv_q    <= 1'b0;
      pl_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      ok_q    <= ok_d;
      errp_q  <= errp_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      pd_q    <= pd_d;
    end
  end

  assign pkt_data    = pd_q;
  assign pkt_valid   = pv_q;
  assign pkt_last    = pl_q;
  assign frame_ok    = ok_q;
  assign frame_err   = errp_q;
  assign err_code    = err_q;
  assign overrun_cnt = ovr_q;
  assign busy        = (state_q != HUNT);

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sits directly downstream of the UART byte receiver. Consumes its `data`/`data_valid` byte stream and parses framed packets: SYNC, LEN, LEN payload bytes, XOR checksum.
- Buffers each payload internally and releases it to the consumer over a valid/ready stream only after the checksum passes, so the consumer never sees a corrupt frame.
- Enforces an inter-byte timeout, flags errors, and counts bytes dropped while draining.

Parameters:
- CLK_Hz, 66_000_000.0, system clock frequency.
- BITRATE_bps, 9_600.0, UART line rate.
- TIMEOUT_BITS, 20, inter-byte timeout expressed in bit times.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload length in bytes (1..255).
- Derived: TIMEOUT_CLK = int'(CLK_Hz / BITRATE_bps * TIMEOUT_BITS); LW = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- pkt_data  out  8  payload byte
- pkt_valid  out  1  pkt_data valid
- pkt_ready  in  1  consumer accepts byte when pkt_valid & pkt_ready
- pkt_last  out  1  marks final payload byte
- frame_ok  out  1  one-cycle pulse, frame accepted
- frame_err  out  1  one-cycle pulse, frame rejected
- err_code  out  2  0 none, 1 LEN, 2 CSUM, 3 TIMEOUT; held until next frame_ok/frame_err
- overrun_cnt  out  8  bytes dropped during DRAIN, saturating
- busy  out  1  state != HUNT

Behaviour:
- Reset: every output is 0, state = HUNT, all counters cleared.
  - rst asserted mid-frame or mid-drain aborts immediately. No frame_err is raised, and buffered data is discarded.
- Only rx_valid cycles are significant. rx_data is ignored otherwise.
- HUNT:
  - rx_valid with rx_data == SYNC_BYTE → LEN.
  - Any other byte is discarded silently.
- LEN:
  - On rx_valid: if 0 < byte <= MAX_LEN, store len, set csum = byte, idx = 0, and go to PAYLOAD.
  - Otherwise pulse frame_err, set err_code = 1, and go to HUNT.
- PAYLOAD:
  - On rx_valid: buf[idx] = byte, csum ^= byte, idx++.
  - When idx reaches len → CSUM.
- CSUM:
  - On rx_valid: if byte == csum, pulse frame_ok, set err_code = 0, rd = 0, and go to DRAIN.
  - Otherwise pulse frame_err, set err_code = 2, and go to HUNT.
- DRAIN:
  - Outputs are registered. pkt_valid = 1 starting the cycle after the frame_ok pulse.
  - pkt_data = buf[rd]. pkt_last = (rd == len-1).
  - On handshake, rd++. On handshake with pkt_last, pkt_valid drops the next cycle and state → HUNT.
  - pkt_data, pkt_valid and pkt_last are stable while pkt_valid & !pkt_ready.
  - rx_valid during DRAIN: the byte is dropped and overrun_cnt increments, saturating at 255. overrun_cnt clears only on rst.
- Timeout:
  - Counter resets on every rx_valid and on entry to LEN.
  - It counts in LEN, PAYLOAD and CSUM. On reaching TIMEOUT_CLK: pulse frame_err, set err_code = 3, and go to HUNT.
  - If rx_valid arrives in the same cycle the counter expires, the byte wins: it is processed and no timeout fires.
  - The counter is idle in HUNT and DRAIN.
- A byte equal to SYNC_BYTE inside LEN, PAYLOAD or CSUM is treated as data. There is no resync.
- frame_ok and frame_err are never asserted in the same cycle.

Decomposition:
- Package uart_pkg:
  - state enum {HUNT, LEN, PAYLOAD, CSUM, DRAIN}
  - err_code enum {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT}
  - default SYNC_BYTE
- Sub-module uart_frame_buf: MAX_LEN x 8 register array, one synchronous write port and one read port. Read is combinational from the rd index, registered in the parent.

Test Plan (sim parameters CLK_Hz=1_000_000, BITRATE_bps=100_000, giving TIMEOUT_CLK = 200; bytes driven as rx_valid pulses 10 clk apart; pkt_ready=1 unless stated):
- Good frame A5 03 11 22 33 03 → frame_ok pulse one cycle after the last byte; pkt stream 11, 22, 33 with pkt_last on 33; err_code = 0; busy low after the last handshake.
- Bad checksum A5 03 11 22 33 04 → frame_err pulse, err_code = 2, no pkt_valid ever, state back in HUNT; a following good frame is accepted.
- Length errors A5 00 and A5 11 (17 > MAX_LEN) → frame_err, err_code = 1 each time; garbage 00 FF before A5 is ignored.
- Timeout: A5 02 11, then silence for 200 clk → frame_err at exactly 200 clocks after the 11 strobe, err_code = 3. A variant strobing a byte on cycle 200 → no timeout.
- Backpressure: good frame with pkt_ready toggling 1/0 every other cycle → data stable while stalled, order preserved. Three rx_valid strobes during DRAIN → overrun_cnt = 3.
- Reset mid-PAYLOAD (after A5 04 11): rst one cycle → all outputs 0, no frame_err; the next good frame passes.
